// File: rtl/agg_pkg.sv
// Shared definitions for the aggregation stage: memory geometry, address map,
// count clamp, accumulator sizing and the FSM state encoding.
// The optional min/max tracking (AGG_MINMAX_EN) adds four states to the enum.
package agg_pkg;

  localparam int WORD_W    = 16;
  localparam int ADDR_W    = 11;
  localparam int MAX_COUNT = 64;
  localparam int CNT_W     = $clog2(MAX_COUNT + 1);
  // Sized so MAX_COUNT full-scale samples can never overflow the sum.
  localparam int ACC_W     = WORD_W + CNT_W;

  localparam logic [ADDR_W-1:0] FLAG_ADDR = 11'h2;
  localparam logic [ADDR_W-1:0] CNT_ADDR  = 11'h3;
  localparam logic [ADDR_W-1:0] AVG_ADDR  = 11'h4;
  localparam logic [ADDR_W-1:0] DATA_BASE = 11'h10;
`ifdef AGG_MINMAX_EN
  localparam logic [ADDR_W-1:0] MIN_ADDR  = AVG_ADDR + 11'd1;
  localparam logic [ADDR_W-1:0] MAX_ADDR  = AVG_ADDR + 11'd2;
`endif

  typedef enum logic [3:0] {
    ST_WAIT,
    ST_IDLE,
    ST_RD_CNT,
    ST_LD_CNT,
    ST_ACC,
    ST_DIV_GO,
    ST_DIV,
    ST_WR_AVG,
    ST_GAP_AVG,
`ifdef AGG_MINMAX_EN
    ST_WR_MIN,
    ST_GAP_MIN,
    ST_WR_MAX,
    ST_GAP_MAX,
`endif
    ST_WR_CLR,
    ST_DONE
  } state_e;

  // Raw count words above MAX_COUNT are treated as MAX_COUNT.
  function automatic logic [CNT_W-1:0] clamp_count(input logic [WORD_W-1:0] raw);
    if (raw > WORD_W'(MAX_COUNT)) return CNT_W'(MAX_COUNT);
    return raw[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/agg_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, N_W cycles per divide.
// start loads the operands (divisor must be non-zero); done pulses for one
// cycle when quotient is valid, and quotient holds until the next start.
module agg_divider
  import agg_pkg::*;
#(
  parameter int N_W = ACC_W,
  parameter int D_W = CNT_W,
  parameter int Q_W = WORD_W
) (
  input  logic           clock,
  input  logic           nrst,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           busy,
  output logic           done,
  output logic [Q_W-1:0] quotient
);

  localparam int STEP_W = $clog2(N_W + 1);

  logic [D_W-1:0]    rem_q,   rem_d;
  logic [N_W-1:0]    quo_q,   quo_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic              done_q,  done_d;

  // Partial remainder has one extra bit after the shift; the remainder always
  // stays below the divisor, so D_W bits are enough to hold it between steps.
  logic [D_W:0] shifted;
  logic [D_W:0] diff;

  // One restoring step per cycle while steps remain; start reloads operands.
  always_comb begin
    shifted = {rem_q, quo_q[N_W-1]};
    diff    = shifted - {1'b0, divisor};
    rem_d   = rem_q;
    quo_d   = quo_q;
    steps_d = steps_q;
    done_d  = 1'b0;
    if (start) begin
      rem_d   = '0;
      quo_d   = dividend;
      steps_d = STEP_W'(N_W);
    end else if (steps_q != '0) begin
      if (!diff[D_W]) begin
        rem_d = diff[D_W-1:0];
        quo_d = {quo_q[N_W-2:0], 1'b1};
      end else begin
        rem_d = shifted[D_W-1:0];
        quo_d = {quo_q[N_W-2:0], 1'b0};
      end
      steps_d = steps_q - STEP_W'(1);
      if (steps_q == STEP_W'(1)) done_d = 1'b1;
    end
  end

  // Divider state registers, synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!nrst) begin
      rem_q   <= '0;
      quo_q   <= '0;
      steps_q <= '0;
      done_q  <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      steps_q <= steps_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (steps_q != '0);
  assign done     = done_q;
  assign quotient = quo_q[Q_W-1:0];

endmodule

// File: rtl/aggregate_data.sv
// Aggregation stage: reads the sample count and samples from the shared
// memory, writes their integer average to AVG_ADDR, then clears the flag word.
// Optional feature macro AGG_MINMAX_EN: also writes min to AVG_ADDR+1 and max
// to AVG_ADDR+2 between the average write and the flag clear.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// WAIT       | idle after reset / after done; waits for en (done held)
// IDLE       | armed; waits for start, samples forAggregation
// RD_CNT     | count address on the bus
// LD_CNT     | count word arrives; clamp, pick first sample address
// ACC        | stream cnt samples into the accumulator (cnt+1 cycles)
// DIV_GO     | launch the divider
// DIV        | wait for the quotient
// WR_AVG     | average write strobe
// GAP_AVG    | idle cycle after the average write
// WR_MIN     | min write strobe (AGG_MINMAX_EN)
// GAP_MIN    | idle cycle after the min write (AGG_MINMAX_EN)
// WR_MAX     | max write strobe (AGG_MINMAX_EN)
// GAP_MAX    | idle cycle after the max write (AGG_MINMAX_EN)
// WR_CLR     | flag-clear write strobe
// DONE       | idle cycle after the clear; raises done, returns to WAIT
module aggregate_data
  import agg_pkg::*;
(
  input  logic              clock,
  input  logic              nrst,
  input  logic              en,
  input  logic              start,
  input  logic              forAggregation,
  input  logic [WORD_W-1:0] data_in,
  output logic [ADDR_W-1:0] address,
  output logic              wr_en,
  output logic [WORD_W-1:0] data_out,
  output logic              done
);

  state_e            state_q,    state_d;
  logic [ADDR_W-1:0] address_q,  address_d;
  logic              wr_en_q,    wr_en_d;
  logic [WORD_W-1:0] data_out_q, data_out_d;
  logic              done_q,     done_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [CNT_W-1:0]  idx_q,      idx_d;
  logic [ACC_W-1:0]  acc_q,      acc_d;
`ifdef AGG_MINMAX_EN
  logic [WORD_W-1:0] min_q,      min_d;
  logic [WORD_W-1:0] max_q,      max_d;
`endif

  logic              div_start;
  logic              div_busy;
  logic              div_done;
  logic [WORD_W-1:0] div_quot;

  agg_divider #(
    .N_W (ACC_W),
    .D_W (CNT_W),
    .Q_W (WORD_W)
  ) u_div (
    .clock    (clock),
    .nrst     (nrst),
    .start    (div_start),
    .dividend (acc_q),
    .divisor  (cnt_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

  // Next-state, address counter, accumulator and write mux.
  always_comb begin
    state_d    = state_q;
    address_d  = address_q;
    wr_en_d    = 1'b0;
    data_out_d = data_out_q;
    done_d     = done_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    div_start  = 1'b0;
`ifdef AGG_MINMAX_EN
    min_d      = min_q;
    max_d      = max_q;
`endif

    case (state_q)
      ST_WAIT: begin
        if (en) begin
          done_d    = 1'b0;
          address_d = CNT_ADDR;
          state_d   = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (start) begin
          if (forAggregation) begin
            address_d = CNT_ADDR;
            state_d   = ST_RD_CNT;
          end else begin
            state_d   = ST_DONE;
          end
        end
      end

      ST_RD_CNT: state_d = ST_LD_CNT;

      ST_LD_CNT: begin
        cnt_d = clamp_count(data_in);
        acc_d = '0;
        idx_d = '0;
`ifdef AGG_MINMAX_EN
        min_d = '0;
        max_d = '0;
`endif
        if (cnt_d == '0) begin
          // Nothing to average: write 0 without touching the sample area.
          address_d  = AVG_ADDR;
          data_out_d = '0;
          wr_en_d    = 1'b1;
          state_d    = ST_WR_AVG;
        end else begin
          address_d  = DATA_BASE;
          state_d    = ST_ACC;
        end
      end

      ST_ACC: begin
        // idx counts cycles in ACC; data for address idx-1 arrives at idx.
        if (idx_q != '0) begin
          acc_d = acc_q + ACC_W'(data_in);
`ifdef AGG_MINMAX_EN
          if (idx_q == CNT_W'(1)) begin
            min_d = data_in;
            max_d = data_in;
          end else begin
            if (data_in < min_q) min_d = data_in;
            if (data_in > max_q) max_d = data_in;
          end
`endif
        end
        // Stop advancing once the last sample address is on the bus.
        if ((idx_q + CNT_W'(1)) < cnt_q) address_d = address_q + ADDR_W'(1);
        if (idx_q == cnt_q) state_d = ST_DIV_GO;
        else                idx_d   = idx_q + CNT_W'(1);
      end

      ST_DIV_GO: begin
        if (!div_busy) begin
          div_start = 1'b1;
          state_d   = ST_DIV;
        end
      end

      ST_DIV: begin
        if (div_done) begin
          address_d  = AVG_ADDR;
          data_out_d = div_quot;
          wr_en_d    = 1'b1;
          state_d    = ST_WR_AVG;
        end
      end

      ST_WR_AVG: state_d = ST_GAP_AVG;

      ST_GAP_AVG: begin
`ifdef AGG_MINMAX_EN
        address_d  = MIN_ADDR;
        data_out_d = min_q;
        wr_en_d    = 1'b1;
        state_d    = ST_WR_MIN;
`else
        address_d  = FLAG_ADDR;
        data_out_d = '0;
        wr_en_d    = 1'b1;
        state_d    = ST_WR_CLR;
`endif
      end

`ifdef AGG_MINMAX_EN
      ST_WR_MIN: state_d = ST_GAP_MIN;

      ST_GAP_MIN: begin
        address_d  = MAX_ADDR;
        data_out_d = max_q;
        wr_en_d    = 1'b1;
        state_d    = ST_WR_MAX;
      end

      ST_WR_MAX: state_d = ST_GAP_MAX;

      ST_GAP_MAX: begin
        address_d  = FLAG_ADDR;
        data_out_d = '0;
        wr_en_d    = 1'b1;
        state_d    = ST_WR_CLR;
      end
`endif

      ST_WR_CLR: state_d = ST_DONE;

      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_WAIT;
      end

      default: state_d = ST_WAIT;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clock) begin
    if (!nrst) begin
      state_q    <= ST_WAIT;
      address_q  <= CNT_ADDR;
      wr_en_q    <= 1'b0;
      data_out_q <= '0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      acc_q      <= '0;
`ifdef AGG_MINMAX_EN
      min_q      <= '0;
      max_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      address_q  <= address_d;
      wr_en_q    <= wr_en_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
`ifdef AGG_MINMAX_EN
      min_q      <= min_d;
      max_q      <= max_d;
`endif
    end
  end

  assign address  = address_q;
  assign wr_en    = wr_en_q;
  assign data_out = data_out_q;
  assign done     = done_q;

endmodule

// File: tb/tb_aggregate_data.sv
// Bench for aggregate_data: behavioural memory, write logger and a reference
// model that computes the expected write sequence from the sample list.
module tb_aggregate_data;

  logic        clock = 1'b0;
  logic        nrst;
  logic        en;
  logic        start;
  logic        fa;
  logic [15:0] data_in;
  logic [10:0] address;
  logic        wr_en;
  logic [15:0] data_out;
  logic        done;

  logic [15:0] mem [0:2047];
  logic [15:0] smp [0:255];
  logic [26:0] wlog [$];
  logic [26:0] wexp [$];

  int checks = 0;
  int errors = 0;
  bit prev_wr = 1'b0;
  int max_addr = 0;

  aggregate_data dut (
    .clock          (clock),
    .nrst           (nrst),
    .en             (en),
    .start          (start),
    .forAggregation (fa),
    .data_in        (data_in),
    .address        (address),
    .wr_en          (wr_en),
    .data_out       (data_out),
    .done           (done)
  );

  always #5 clock = ~clock;

  // Memory read data valid one cycle after the address.
  always @(posedge clock) data_in <= mem[address];

  // Log writes and watch for back-to-back strobes.
  always @(negedge clock) begin
    if (nrst) begin
      if (wr_en) begin
        checks++;
        if (prev_wr) begin
          errors++;
          $display("FAIL wr_gap: wr_en high on consecutive cycles, addr=%h got=1 want=0", address);
        end
        wlog.push_back({address, data_out});
      end
      if (int'(address) > max_addr) max_addr = int'(address);
    end
    prev_wr = wr_en;
  end

  // Reference: expected write list from the sample values with plain arithmetic.
  task automatic build_expected(input int cnt_word, input bit fa_start);
    int n;
    longint sum;
    int mn, mx, avg;
    logic [10:0] a;
    logic [15:0] d;
    wexp.delete();
    if (!fa_start) return;
    n = (cnt_word > 64) ? 64 : cnt_word;
    sum = 0; mn = 0; mx = 0;
    for (int i = 0; i < n; i++) begin
      sum += smp[i];
      if (i == 0 || int'(smp[i]) < mn) mn = int'(smp[i]);
      if (i == 0 || int'(smp[i]) > mx) mx = int'(smp[i]);
    end
    avg = (n == 0) ? 0 : int'(sum / n);
    a = 11'h4; d = 16'(avg); wexp.push_back({a, d});
`ifdef AGG_MINMAX_EN
    a = 11'h5; d = 16'(mn); wexp.push_back({a, d});
    a = 11'h6; d = 16'(mx); wexp.push_back({a, d});
`endif
    a = 11'h2; d = 16'h0; wexp.push_back({a, d});
  endtask

  task automatic do_op(input string name, input int cnt_word, input bit fa_start,
                       input bit fa_later, output int cyc);
    mem[3] = 16'(cnt_word);
    mem[2] = 16'h1;
    for (int i = 0; i < 256; i++) mem[16 + i] = smp[i];
    build_expected(cnt_word, fa_start);
    @(negedge clock);
    en = 1'b1;
    @(negedge clock);
    en = 1'b0;
    wlog.delete();
    max_addr = 0;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s en_clears_done: got=%b want=0", name, done);
    end
    start = 1'b1;
    fa = fa_start;
    @(negedge clock);
    start = 1'b0;
    fa = fa_later;
    cyc = 1;
    while (done !== 1'b1 && cyc < 500) begin
      @(negedge clock);
      cyc++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s done_timeout: got=%b want=1", name, done);
    end
    checks++;
    if (wlog.size() != wexp.size()) begin
      errors++;
      $display("FAIL %s write_count: got=%0d want=%0d", name, wlog.size(), wexp.size());
    end else begin
      for (int i = 0; i < wexp.size(); i++) begin
        checks++;
        if (wlog[i] !== wexp[i]) begin
          errors++;
          $display("FAIL %s write[%0d]: got addr=%h data=%h want addr=%h data=%h", name, i,
                   wlog[i][26:16], wlog[i][15:0], wexp[i][26:16], wexp[i][15:0]);
        end
      end
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (wr_en !== 1'b0)     begin errors++; $display("FAIL reset_wr_en: got=%b want=0", wr_en); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got=%b want=0", done); end
    checks++; if (address !== 11'h3)  begin errors++; $display("FAIL reset_address: got=%h want=003", address); end
    checks++; if (data_out !== 16'h0) begin errors++; $display("FAIL reset_data_out: got=%h want=0000", data_out); end
    nrst = 1'b1;
  endtask

  task automatic test_basic();
    int cyc;
    smp[0] = 16'd10; smp[1] = 16'd20; smp[2] = 16'd30; smp[3] = 16'd41;
    do_op("basic", 4, 1'b1, 1'b1, cyc);
  endtask

  task automatic test_no_agg();
    int cyc;
    do_op("no_agg", 4, 1'b0, 1'b0, cyc);
    checks++;
    if (cyc > 3) begin
      errors++;
      $display("FAIL no_agg_latency: got=%0d cycles want<=3", cyc);
    end
  endtask

  task automatic test_zero();
    int cyc;
    do_op("zero", 0, 1'b1, 1'b1, cyc);
    checks++;
    if (max_addr >= 16) begin
      errors++;
      $display("FAIL zero_no_sample_read: max address got=%h want<010", max_addr);
    end
  endtask

  task automatic test_clamp();
    int cyc;
    for (int i = 0; i < 256; i++) smp[i] = 16'hFFFF;
    do_op("clamp", 200, 1'b1, 1'b1, cyc);
  endtask

  task automatic test_minmax_samples();
    int cyc;
    smp[0] = 16'd7; smp[1] = 16'd3; smp[2] = 16'd9;
    do_op("three", 3, 1'b1, 1'b1, cyc);
  endtask

  task automatic test_fa_sampling();
    int cyc;
    for (int i = 0; i < 8; i++) smp[i] = 16'($urandom_range(0, 1000));
    do_op("fa_drop", 5, 1'b1, 1'b0, cyc);
    do_op("fa_rise", 5, 1'b0, 1'b1, cyc);
  endtask

  task automatic test_random();
    int cyc;
    int n;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 256; i++) smp[i] = 16'($urandom);
      n = $urandom_range(1, 80);
      do_op($sformatf("rand%0d", k), n, 1'b1, 1'b1, cyc);
    end
  endtask

  task automatic test_en_start_same();
    int cyc;
    @(negedge clock);
    en = 1'b1; start = 1'b1; fa = 1'b1;
    @(negedge clock);
    en = 1'b0; start = 1'b0;
    wlog.delete();
    repeat (6) @(negedge clock);
    checks++;
    if (wlog.size() != 0) begin
      errors++;
      $display("FAIL en_start_same_writes: got=%0d want=0", wlog.size());
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL en_start_same_done: got=%b want=0", done);
    end
    smp[0] = 16'd100; smp[1] = 16'd201;
    do_op("after_drop", 2, 1'b1, 1'b1, cyc);
  endtask

  task automatic test_reset_mid();
    int cyc;
    for (int i = 0; i < 256; i++) smp[i] = 16'($urandom);
    mem[3] = 16'd50;
    for (int i = 0; i < 256; i++) mem[16 + i] = smp[i];
    @(negedge clock); en = 1'b1;
    @(negedge clock); en = 1'b0; start = 1'b1; fa = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (10) @(negedge clock);
    nrst = 1'b0;
    @(negedge clock);
    checks++; if (wr_en !== 1'b0)    begin errors++; $display("FAIL midrst_wr_en: got=%b want=0", wr_en); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL midrst_done: got=%b want=0", done); end
    checks++; if (address !== 11'h3) begin errors++; $display("FAIL midrst_address: got=%h want=003", address); end
    nrst = 1'b1;
    wlog.delete();
    start = 1'b1; fa = 1'b1;
    repeat (3) @(negedge clock);
    start = 1'b0;
    repeat (100) @(negedge clock);
    checks++;
    if (wlog.size() != 0) begin
      errors++;
      $display("FAIL midrst_writes_without_en: got=%0d want=0", wlog.size());
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_done_without_en: got=%b want=0", done);
    end
    do_op("after_reset", 50, 1'b1, 1'b1, cyc);
  endtask

  initial begin
    nrst = 1'b0; en = 1'b0; start = 1'b0; fa = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0;
    for (int i = 0; i < 256; i++) smp[i] = 16'h0;
    test_reset();
    test_basic();
    test_no_agg();
    test_zero();
    test_clamp();
    test_minmax_samples();
    test_fa_sampling();
    test_en_start_same();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
